// File: rtl/p_encoder_pkg.sv
// Shared definitions for the p_encoder priority encoder.
// Holds the width limit and the ceil-log2 helper used to size the tree.
package p_encoder_pkg;

  localparam int unsigned P_ENCODER_MAX_WIDTH = 1024;

  // Never returns less than 1 so a 2-bit encoder still has a 1-bit index.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/p_encoder_node.sv
// Combinational merge of two (valid, index) pairs from the lower and upper halves.
// The upper half wins whenever it is valid; its valid becomes the new index MSB.
module p_encoder_node
  import p_encoder_pkg::*;
#(
  parameter int unsigned LW = 1
) (
  input  logic          vl,
  input  logic [LW-1:0] il,
  input  logic          vh,
  input  logic [LW-1:0] ih,
  output logic          vo,
  output logic [LW:0]   io
);

  assign vo = vh | vl;
  assign io = {vh, vh ? ih : il};

endmodule

// File: rtl/p_encoder.sv
// Registered priority encoder: o is the index of the highest set bit of a, v flags a != 0.
// Optional registered one-hot output oh when P_ENCODER_ONEHOT_EN is defined.
module p_encoder
  import p_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = 31,
  localparam int unsigned OW = clog2_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
`ifdef P_ENCODER_ONEHOT_EN
  output logic [WIDTH-1:0] oh,
`endif
  output logic [OW-1:0]    o,
  output logic             v
);

  localparam int unsigned PW = 1 << OW;

  if (WIDTH < 2 || WIDTH > P_ENCODER_MAX_WIDTH) begin : g_width_check
    $error("p_encoder: WIDTH %0d outside 2..%0d", WIDTH, P_ENCODER_MAX_WIDTH);
  end

  // Zero padding up to a power of two keeps the tree regular; padded bits never win.
  logic [PW-1:0] pad;
  if (PW > WIDTH) begin : g_pad
    assign pad = {{(PW - WIDTH){1'b0}}, a};
  end else begin : g_nopad
    assign pad = a;
  end

  // Level l holds PW>>l nodes, each with an l-bit index into its 2^l-bit span.
  for (genvar l = 1; l <= OW; l++) begin : g_lvl
    localparam int unsigned N = PW >> l;
    logic [N-1:0] vld;
    logic [l-1:0] idx [N];

    for (genvar j = 0; j < N; j++) begin : g_node
      if (l == 1) begin : g_leaf
        assign vld[j] = pad[2*j+1] | pad[2*j];
        assign idx[j] = pad[2*j+1];
      end else begin : g_merge
        p_encoder_node #(
          .LW(l - 1)
        ) u_node (
          .vl(g_lvl[l-1].vld[2*j]),
          .il(g_lvl[l-1].idx[2*j]),
          .vh(g_lvl[l-1].vld[2*j+1]),
          .ih(g_lvl[l-1].idx[2*j+1]),
          .vo(vld[j]),
          .io(idx[j])
        );
      end
    end
  end

  logic          tree_vld;
  logic [OW-1:0] tree_idx;
  assign tree_vld = g_lvl[OW].vld[0];
  assign tree_idx = g_lvl[OW].idx[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      o <= '0;
      v <= 1'b0;
    end else begin
      o <= tree_idx;
      v <= tree_vld;
    end
  end

`ifdef P_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0] oh_d;
  assign oh_d = tree_vld ? (WIDTH'(1) << tree_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      oh <= '0;
    end else begin
      oh <= oh_d;
    end
  end
`endif

endmodule

// File: tb/tb_p_encoder.sv
// Scoreboard bench for p_encoder at WIDTH=31: expected results are queued when a is
// driven and compared against the registered outputs one cycle later.
module tb_p_encoder;

  localparam int unsigned W  = 31;
  localparam int unsigned OW = 5;

  typedef struct {
    string         tag;
    logic [OW-1:0] o;
    logic          v;
    logic [W-1:0]  oh;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a;
  logic [OW-1:0] o;
  logic          v;
`ifdef P_ENCODER_ONEHOT_EN
  logic [W-1:0]  oh;
`endif

  int   n_vec;
  int   n_miss;
  exp_t sb[$];

  p_encoder #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
`ifdef P_ENCODER_ONEHOT_EN
    .oh (oh),
`endif
    .o  (o),
    .v  (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: scan upward so the last set bit seen is the highest one.
  function automatic exp_t model(input string tag, input logic r, input logic [W-1:0] x);
    exp_t e;
    e.tag = tag;
    e.o   = '0;
    e.v   = 1'b0;
    e.oh  = '0;
    if (!r) begin
      for (int i = 0; i < int'(W); i++) begin
        if (x[i]) begin
          e.o = OW'(i);
          e.v = 1'b1;
        end
      end
      if (e.v) e.oh = W'(1) << e.o;
    end
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".o"}, 64'(o), 64'(e.o));
      check({e.tag, ".v"}, 64'(v), 64'(e.v));
`ifdef P_ENCODER_ONEHOT_EN
      check({e.tag, ".oh"}, 64'(oh), 64'(e.oh));
`endif
    end
  endtask

  // Compare the result of the previous drive, then drive the next input.
  task automatic step(input string tag, input logic r, input logic [W-1:0] x);
    @(negedge clk);
    compare_head();
    rst = r;
    a   = x;
    sb.push_back(model(tag, r, x));
  endtask

  task automatic direct(input string tag, input logic [OW-1:0] exp_o, input logic exp_v);
    @(negedge clk);
    compare_head();
    check({tag, ".direct_o"}, 64'(o), 64'(exp_o));
    check({tag, ".direct_v"}, 64'(v), 64'(exp_v));
  endtask

  initial begin
    longint k;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    a      = '0;

    step("rst0", 1'b1, 31'h7FFFFFFF);
    step("rst1", 1'b1, 31'h7FFFFFFF);
    step("post_rst", 1'b0, 31'h7FFFFFFF);
    // Spot check of the first post-reset result against fixed values.
    @(negedge clk);
    compare_head();
    check("post_rst.fixed_o", 64'(o), 64'd30);
    check("post_rst.fixed_v", 64'(v), 64'd1);
    rst = 1'b0;

    step("zero", 1'b0, 31'd0);
    step("bits4_0", 1'b0, 31'd17);
    step("bit0", 1'b0, 31'd1);

    k = 0;
    while (k < (64'd1 << 31)) begin
      step($sformatf("sweep_%0d", k), 1'b0, W'(k));
      k = (k << 1) + 17;
    end

    step("bit30", 1'b0, 31'h40000000);
    step("bit30_0", 1'b0, 31'h40000001);
    step("bit1", 1'b0, 31'd2);
    step("ones", 1'b0, 31'h7FFFFFFF);

    step("k527", 1'b0, 31'd527);
    direct("k527", 5'd9, 1'b1);
    step("k51", 1'b0, 31'd51);
    direct("k51", 5'd5, 1'b1);

    for (int i = 0; i < 6; i++) begin
      step($sformatf("b2b_%0d", i), 1'b0, (i % 2 == 0) ? 31'h00008000 : 31'd0);
    end

    step("mid_rst", 1'b1, 31'h00008000);
    step("after_mid_rst", 1'b0, 31'h00000300);

`ifdef P_ENCODER_ONEHOT_EN
    step("oh_f0f0", 1'b0, 31'h0000F0F0);
    step("oh_zero", 1'b0, 31'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      step($sformatf("rand_%0d", i), 1'b0, W'($urandom));
    end

    @(negedge clk);
    compare_head();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
